// File: rtl/debug_cmd_responder.sv
// UART debug command front-end: decodes a command byte, snapshots a probe word and
// streams the response out one byte per uart frame using the transmit/is_transmitting handshake.
module debug_cmd_responder #(
    parameter int unsigned NUM_PROBES  = 4,
    parameter int unsigned PROBE_WIDTH = 32
) (
    input  logic                               iCE_CLK,
    input  logic                               reset,
    input  logic [NUM_PROBES*PROBE_WIDTH-1:0]  probes,
    input  logic                               received,
    input  logic [7:0]                         rx_byte,
    input  logic                               is_transmitting,
    output logic                               transmit,
    output logic [7:0]                         tx_byte,
    output logic                               busy,
    output logic                               cmd_error,
    output logic                               overrun
);
    localparam int unsigned NumBytes  = PROBE_WIDTH / 8;
    localparam int unsigned RespWidth = PROBE_WIDTH + 8;
    localparam int unsigned CntWidth  = $clog2(NumBytes + 2);

    typedef enum logic [2:0] {StIdle, StLoad, StSend, StWaitStart, StWaitDone} state_e;

    state_e                 state_q, state_d;
    logic [RespWidth-1:0]   resp_q, resp_d;
    logic [CntWidth-1:0]    count_q, count_d;
    logic [7:0]             tx_byte_q, tx_byte_d;
    logic                   cmd_error_q, cmd_error_d;
    logic                   overrun_q, overrun_d;
    logic [PROBE_WIDTH-1:0] probe_sel;
    logic [7:0]             next_byte;
    logic                   is_probe;

    assign is_probe = ({24'd0, rx_byte} < NUM_PROBES);

    always_comb begin
        probe_sel = '0;
        for (int k = 0; k < int'(NUM_PROBES); k++) begin
            if (rx_byte == 8'(k)) probe_sel = probes[k*PROBE_WIDTH +: PROBE_WIDTH];
        end
    end

    // Byte slot i of resp_q is sent when count_q == i+1; the header sits in the top slot.
    always_comb begin
        next_byte = 8'h00;
        for (int i = 0; i <= int'(NumBytes); i++) begin
            if (count_q == CntWidth'(i + 1)) next_byte = resp_q[i*8 +: 8];
        end
    end

    always_comb begin
        state_d     = state_q;
        resp_d      = resp_q;
        count_d     = count_q;
        tx_byte_d   = tx_byte_q;
        cmd_error_d = 1'b0;
        overrun_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (received) begin
                    state_d = StLoad;
                    if (is_probe) begin
                        resp_d  = {rx_byte, probe_sel};
                        count_d = CntWidth'(NumBytes + 1);
                    end else begin
                        resp_d      = {{PROBE_WIDTH{1'b0}}, (rx_byte == 8'hFF) ? 8'h55 : 8'hEE};
                        count_d     = CntWidth'(1);
                        cmd_error_d = (rx_byte != 8'hFF);
                    end
                end
            end
            StLoad: begin
                tx_byte_d = next_byte;
                if (!is_transmitting) state_d = StSend;
            end
            StSend: state_d = StWaitStart;
            StWaitStart: begin
                if (is_transmitting) state_d = StWaitDone;
            end
            StWaitDone: begin
                if (!is_transmitting) begin
                    if (count_q == CntWidth'(1)) begin
                        state_d = StIdle;
                    end else begin
                        count_d = count_q - CntWidth'(1);
                        state_d = StLoad;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // Commands arriving mid-response (including the final WAIT_DONE cycle) are dropped.
        if (received && (state_q != StIdle)) overrun_d = 1'b1;
    end

    always_ff @(posedge iCE_CLK or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            resp_q      <= '0;
            count_q     <= '0;
            tx_byte_q   <= 8'h00;
            cmd_error_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            resp_q      <= resp_d;
            count_q     <= count_d;
            tx_byte_q   <= tx_byte_d;
            cmd_error_q <= cmd_error_d;
            overrun_q   <= overrun_d;
        end
    end

    assign transmit  = (state_q == StSend);
    assign busy      = (state_q != StIdle);
    assign tx_byte   = tx_byte_q;
    assign cmd_error = cmd_error_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_debug_cmd_responder.sv
// Randomized bench for debug_cmd_responder: a behavioural uart model feeds is_transmitting,
// and every captured response is compared against the expected byte sequence of the command.
module tb_debug_cmd_responder;
    localparam int NP = 4;
    localparam int PW = 32;
    localparam int NB = PW / 8;

    logic             iCE_CLK = 1'b0;
    logic             reset = 1'b1;
    logic [NP*PW-1:0] probes = '0;
    logic             received = 1'b0;
    logic [7:0]       rx_byte = 8'h00;
    logic             is_transmitting = 1'b0;
    logic             transmit;
    logic [7:0]       tx_byte;
    logic             busy;
    logic             cmd_error;
    logic             overrun;

    always #5 iCE_CLK = ~iCE_CLK;

    debug_cmd_responder #(.NUM_PROBES(NP), .PROBE_WIDTH(PW)) dut (
        .iCE_CLK         (iCE_CLK),
        .reset           (reset),
        .probes          (probes),
        .received        (received),
        .rx_byte         (rx_byte),
        .is_transmitting (is_transmitting),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .busy            (busy),
        .cmd_error       (cmd_error),
        .overrun         (overrun)
    );

    int checks = 0;
    int passed = 0;
    int rise_delay = 0;
    int frame_len = 8;
    int uphase = 0;
    int ucnt = 0;
    int err_pulses = 0;
    int ovr_pulses = 0;
    int dup_err = 0;
    int stab_err = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] last_tx = 8'h00;
    logic       prev_transmit = 1'b0;

    // Uart transmitter model: accepts a strobe, raises busy after rise_delay+1 cycles,
    // stays busy for frame_len+1 cycles.
    always @(posedge iCE_CLK or posedge reset) begin
        if (reset) begin
            uphase <= 0;
            ucnt <= 0;
            is_transmitting <= 1'b0;
        end else begin
            case (uphase)
                0: if (transmit) begin uphase <= 1; ucnt <= rise_delay; end
                1: if (ucnt == 0) begin
                       is_transmitting <= 1'b1; uphase <= 2; ucnt <= frame_len;
                   end else ucnt <= ucnt - 1;
                default: if (ucnt == 0) begin
                       is_transmitting <= 1'b0; uphase <= 0;
                   end else ucnt <= ucnt - 1;
            endcase
        end
    end

    always @(negedge iCE_CLK) begin
        if (!reset) begin
            if (transmit) begin
                if (uphase != 0 || prev_transmit) dup_err++;
                got_q.push_back(tx_byte);
                last_tx = tx_byte;
            end else if (uphase != 0 && tx_byte !== last_tx) begin
                stab_err++;
            end
            if (cmd_error) err_pulses++;
            if (overrun) ovr_pulses++;
            prev_transmit = transmit;
        end
    end

    function automatic void expect_cmd(input logic [7:0] b);
        logic [PW-1:0] w;
        exp_q.delete();
        if (int'(b) < NP) begin
            w = probes[int'(b)*PW +: PW];
            exp_q.push_back(b);
            for (int i = NB - 1; i >= 0; i--) exp_q.push_back(w[i*8 +: 8]);
        end else begin
            exp_q.push_back(b == 8'hFF ? 8'h55 : 8'hEE);
        end
    endfunction

    function automatic logic [127:0] pack(input logic [7:0] q[$]);
        logic [127:0] v = '0;
        foreach (q[i]) v = {v[119:0], q[i]};
        return v;
    endfunction

    task automatic randomize_probes();
        for (int k = 0; k < NP; k++) probes[k*PW +: PW] = $urandom;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        @(negedge iCE_CLK);
        rx_byte = b;
        received = 1'b1;
        @(negedge iCE_CLK);
        received = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 5000) begin
            @(negedge iCE_CLK);
            n++;
        end
        if (busy) begin
            checks++;
            $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic run_cmd(input logic [7:0] b);
        expect_cmd(b);
        got_q.delete();
        send_cmd(b);
        wait_idle();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge iCE_CLK);
        checks++; if (transmit !== 1'b0) $display("FAIL reset_transmit: got %b want 0", transmit);
                  else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
                  else passed++;
        checks++; if (tx_byte !== 8'h00) $display("FAIL reset_tx_byte: got %h want 00", tx_byte);
                  else passed++;
        checks++; if (cmd_error !== 1'b0 || overrun !== 1'b0)
                      $display("FAIL reset_pulses: got %b%b want 00", cmd_error, overrun);
                  else passed++;
        reset = 1'b0;
        repeat (5) @(negedge iCE_CLK);
        checks++; if (busy !== 1'b0 || transmit !== 1'b0)
                      $display("FAIL post_reset_idle: busy=%b transmit=%b want 0 0", busy, transmit);
                  else passed++;
    endtask

    task automatic test_probe_read();
        randomize_probes();
        probes[2*PW +: PW] = 32'hDEADBEEF;
        run_cmd(8'h02);
        checks++; if (got_q.size() != 5) $display("FAIL probe2_pulses: got %0d want 5", got_q.size());
                  else passed++;
        checks++; if (pack(got_q) !== 128'h02DEADBEEF)
                      $display("FAIL probe2_bytes: got %h want 02deadbeef", pack(got_q));
                  else passed++;
        for (int t = 0; t < 6; t++) begin
            randomize_probes();
            frame_len = $urandom_range(2, 10);
            run_cmd(8'($urandom_range(0, NP - 1)));
            checks++;
            if (got_q.size() != exp_q.size() || pack(got_q) !== pack(exp_q))
                $display("FAIL probe_rand%0d: got %h want %h", t, pack(got_q), pack(exp_q));
            else passed++;
        end
        frame_len = 8;
    endtask

    task automatic test_ping_error();
        err_pulses = 0;
        run_cmd(8'hFF);
        checks++; if (got_q.size() != 1 || got_q[0] !== 8'h55)
                      $display("FAIL ping: got %h (%0d bytes) want 55", pack(got_q), got_q.size());
                  else passed++;
        checks++; if (err_pulses != 0) $display("FAIL ping_no_err: got %0d want 0", err_pulses);
                  else passed++;
        run_cmd(8'h10);
        checks++; if (got_q.size() != 1 || got_q[0] !== 8'hEE)
                      $display("FAIL bad_10: got %h want ee", pack(got_q));
                  else passed++;
        checks++; if (err_pulses != 1) $display("FAIL bad_10_err: got %0d pulses want 1", err_pulses);
                  else passed++;
        for (int t = 0; t < 3; t++) begin
            logic [7:0] b;
            b = 8'($urandom_range(NP, 254));
            err_pulses = 0;
            run_cmd(b);
            checks++;
            if (pack(got_q) !== pack(exp_q) || err_pulses != 1 || got_q.size() != 1)
                $display("FAIL bad_rand %h: got %h err=%0d want ee err=1", b, pack(got_q), err_pulses);
            else passed++;
        end
    endtask

    task automatic test_snapshot();
        probes[1*PW +: PW] = 32'h12345678;
        expect_cmd(8'h01);
        got_q.delete();
        send_cmd(8'h01);
        probes[1*PW +: PW] = 32'h0;
        wait_idle();
        checks++; if (pack(got_q) !== 128'h0112345678)
                      $display("FAIL snapshot: got %h want 0112345678", pack(got_q));
                  else passed++;
    endtask

    task automatic test_overrun();
        int n = 0;
        randomize_probes();
        ovr_pulses = 0;
        err_pulses = 0;
        expect_cmd(8'h00);
        got_q.delete();
        send_cmd(8'h00);
        while (got_q.size() < 2 && n < 2000) begin @(negedge iCE_CLK); n++; end
        send_cmd(8'h01);
        wait_idle();
        checks++; if (ovr_pulses != 1) $display("FAIL overrun_pulse: got %0d want 1", ovr_pulses);
                  else passed++;
        checks++; if (pack(got_q) !== pack(exp_q) || got_q.size() != exp_q.size())
                      $display("FAIL overrun_resp: got %h want %h", pack(got_q), pack(exp_q));
                  else passed++;
        run_cmd(8'h01);
        checks++; if (pack(got_q) !== pack(exp_q) || ovr_pulses != 1 || err_pulses != 0)
                      $display("FAIL overrun_next: got %h ovr=%0d want %h ovr=1",
                               pack(got_q), ovr_pulses, pack(exp_q));
                  else passed++;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        randomize_probes();
        got_q.delete();
        send_cmd(8'h02);
        while (!(got_q.size() == 3 && is_transmitting) && n < 2000) begin
            @(negedge iCE_CLK);
            n++;
        end
        @(negedge iCE_CLK);
        @(negedge iCE_CLK);
        reset = 1'b1;
        #1;
        checks++; if (transmit !== 1'b0 || busy !== 1'b0 || tx_byte !== 8'h00)
                      $display("FAIL reset_mid: transmit=%b busy=%b tx=%h want 0 0 00",
                               transmit, busy, tx_byte);
                  else passed++;
        @(negedge iCE_CLK);
        reset = 1'b0;
        got_q.delete();
        repeat (100) @(negedge iCE_CLK);
        checks++; if (got_q.size() != 0 || busy !== 1'b0)
                      $display("FAIL reset_mid_quiet: got %0d strobes busy=%b want 0 0",
                               got_q.size(), busy);
                  else passed++;
        run_cmd(8'hFF);
        checks++; if (pack(got_q) !== 128'h55 || got_q.size() != 1)
                      $display("FAIL reset_mid_recover: got %h want 55", pack(got_q));
                  else passed++;
    endtask

    task automatic test_slow_uart();
        rise_delay = 3;
        dup_err = 0;
        randomize_probes();
        run_cmd(8'h03);
        checks++; if (pack(got_q) !== pack(exp_q) || got_q.size() != exp_q.size())
                      $display("FAIL slow_uart: got %h want %h", pack(got_q), pack(exp_q));
                  else passed++;
        checks++; if (dup_err != 0) $display("FAIL slow_uart_dup: got %0d want 0", dup_err);
                  else passed++;
        rise_delay = 0;
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        dup_err = 0;
        stab_err = 0;
        for (int t = 0; t < 10; t++) begin
            logic [7:0] b;
            randomize_probes();
            rise_delay = $urandom_range(0, 2);
            frame_len = $urandom_range(1, 6);
            case ($urandom_range(0, 3))
                0: b = 8'hFF;
                1: b = 8'($urandom_range(NP, 254));
                default: b = 8'($urandom_range(0, NP - 1));
            endcase
            run_cmd(b);
            if (pack(got_q) !== pack(exp_q) || got_q.size() != exp_q.size()) bad++;
        end
        checks++; if (bad != 0) $display("FAIL b2b_resp: got %0d bad responses want 0", bad);
                  else passed++;
        checks++; if (dup_err != 0) $display("FAIL b2b_dup: got %0d want 0", dup_err);
                  else passed++;
        checks++; if (stab_err != 0) $display("FAIL b2b_tx_stable: got %0d changes want 0", stab_err);
                  else passed++;
        rise_delay = 0;
        frame_len = 8;
    endtask

    initial begin
        test_reset();
        test_probe_read();
        test_ping_error();
        test_snapshot();
        test_overrun();
        test_reset_mid();
        test_slow_uart();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
